serial_frame_deserializer: RTL and testbench
============================================

# serial_frame_deserializer

Receive-side stage that consumes the serial bit stream produced by the SISO shift-register chain and turns it into parallel words. Hunts for a fixed sync pattern, collects a DATA_W-bit payload MSB-first and an optional even-parity bit, then presents the word on a valid/ready interface with a one-word output buffer. Sits directly downstream of the serial shift register, with its `d` input driven from the register's `q`.

## Interface
- DATA_W, 8, payload width in bits (2..32)
- SYNC_W, 3, sync pattern width (2..8)
- SYNC, 3'b101, sync pattern, first-received bit is MSB
- PARITY_EN, 1, 1 = one even-parity bit follows the payload; 0 = no parity bit

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- d  in  1  serial data bit from the upstream shift register
- bit_en  in  1  `d` is sampled only on edges where bit_en=1
- data  out  DATA_W  received payload; valid only while `valid`=1
- valid  out  1  output word available
- ready  in  1  consumer accepts the word on an edge with valid&ready
- parity_err  out  1  parity mismatch for the word on `data`; meaningful only with `valid`; 0 when PARITY_EN=0
- overrun  out  1  one-cycle pulse when a completed frame is dropped

## Operation
- FSM states: HUNT, DATA, PAR
- HUNT: each sampled bit shifts into a SYNC_W-bit window. A fill counter counts bits since entering HUNT, saturating at SYNC_W. When the counter has reached SYNC_W and window == SYNC (including the bit sampled on this edge), go to DATA with bit count 0. Overlapping matches are allowed within HUNT.
- DATA: shift sampled bits into the payload register MSB-first. On the DATA_W-th bit, go to PAR if PARITY_EN=1; otherwise complete the frame.
- PAR: the sampled bit is the parity bit. Set parity error = (XOR of payload) != bit. Complete the frame.
- Frame completion:
  - If the buffer is empty, or valid&ready holds on the same edge, load data and parity_err and set valid=1.
  - Otherwise, discard the frame, keep the buffer unchanged, and pulse overrun.
  - In all cases return to HUNT with the window and fill counter cleared. Payload bits never count toward the next sync.
- Buffer: valid stays 1 and data/parity_err stay stable until valid&ready. After acceptance without a simultaneous completion, valid=0 on the next cycle.
- Edges where bit_en=0 change no FSM, window, or counter state. Handshake and buffer logic still run on every edge.

## Timing
- Reset values: data=0, valid=0, parity_err=0, overrun=0, state HUNT, window=0, counters=0. A reset mid-frame abandons the frame and drops any buffered word.
- Latency: valid rises on the edge that samples the last frame bit (parity bit, or last payload bit when PARITY_EN=0), so it is visible the cycle after that bit is presented.
- Minimum frame length is SYNC_W+DATA_W+PARITY_EN sampled bits. Back-to-back frames need no idle bits.
- overrun is high for exactly one cycle, registered on the completion edge.
- ready is ignored while valid=0.

## Structure
- Shared package `serial_rx_pkg` holds the state enum (HUNT, DATA, PAR) and the default constants DATA_W=8, SYNC_W=3, SYNC=3'b101.
- Sub-module `serial_sync_detect`: window shift register plus fill counter, with inputs clk, rst, bit_en, d, clear and output match. Its output is combinational on the current window and d, so a match is detected on the edge that samples the last sync bit.
- The top level holds the FSM, payload shift register, bit counter, parity accumulator and output buffer.

## Test plan
- Defaults, bit_en=1, ready=1. Stream 1,0,1, then 1,0,1,0,0,0,1,1, then parity 0. Expect data=8'hA3, parity_err=0, a one-cycle valid on the cycle after the parity bit, overrun=0.
- Same frame with parity bit 1. Expect data=8'hA3, valid=1, parity_err=1.
- ready=0. Send two frames 8'hA3 then 8'h5C. Expect valid held with data=8'hA3, a one-cycle overrun at the end of the second frame, and data still 8'hA3. Raise ready; expect valid=0 next cycle.
- Noise 0,0,1,1,0,1 (overlapping sync) followed by payload 8'hFF and parity 0. Expect data=8'hFF, with sync detected at the 6th bit.
- bit_en toggling every other cycle over the first frame's bits. Expect the same result as the first scenario. Bits presented while bit_en=0 are ignored.
- rst=0 for one cycle after 5 payload bits. Expect all outputs 0 and state HUNT. A complete fresh frame of 8'h3C is then received correctly.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding and
// default frame geometry (payload width, sync width, sync pattern).
package serial_rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_t;

  localparam int          DEF_DATA_W = 8;
  localparam int          DEF_SYNC_W = 3;
  localparam logic [2:0]  DEF_SYNC   = 3'b101;

endpackage

// File: rtl/serial_sync_detect.sv
// Sliding sync-pattern window with a saturating fill counter; match is
// combinational on the stored window plus the bit being sampled now.
module serial_sync_detect #(
  parameter int                SYNC_W = 3,
  parameter logic [SYNC_W-1:0] SYNC   = 3'b101
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic d,
  input  logic clear,
  output logic match
);

  localparam int            CW       = $clog2(SYNC_W + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(SYNC_W);
  localparam logic [CW-1:0] FILL_PRE = CW'(SYNC_W - 1);

  // Only the SYNC_W-1 older bits are stored; the newest bit is d itself.
  logic [SYNC_W-2:0] window;
  logic [CW-1:0]     fill;
  logic [SYNC_W-1:0] next_win;

  assign next_win = {window, d};
  assign match    = bit_en && (fill >= FILL_PRE) && (next_win == SYNC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (bit_en) begin
      window <= next_win[SYNC_W-2:0];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel receiver: hunts for sync, collects an MSB-first payload
// and optional even-parity bit, and holds the word in a one-entry buffer.
module serial_frame_deserializer
  import serial_rx_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                SYNC_W    = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC      = SYNC_W'(DEF_SYNC),
  parameter bit                PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              overrun
);

  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state, next_state;
  logic [DATA_W-1:0] payload;
  logic [CNT_W-1:0]  bit_cnt;
  logic              par_acc;
  logic              match;
  logic              sync_clear;
  logic              complete;
  logic              frame_perr;
  logic [DATA_W-1:0] frame_word;

  // Window is held cleared outside HUNT so payload bits never feed the next sync.
  assign sync_clear = (state != HUNT) || match;

  serial_sync_detect #(
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .bit_en (bit_en),
    .d      (d),
    .clear  (sync_clear),
    .match  (match)
  );

  // Without a parity bit the word completes on the last payload bit, so d is still in flight.
  assign frame_word = PARITY_EN ? payload : {payload[DATA_W-2:0], d};

  always_ff @(posedge clk) begin
    if (!rst) state <= HUNT;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    frame_perr = 1'b0;
    if (bit_en) begin
      case (state)
        HUNT: if (match) next_state = DATA;
        DATA: begin
          if (bit_cnt == LAST) begin
            if (PARITY_EN) begin
              next_state = PAR;
            end else begin
              next_state = HUNT;
              complete   = 1'b1;
            end
          end
        end
        PAR: begin
          next_state = HUNT;
          complete   = 1'b1;
          frame_perr = par_acc ^ d;
        end
        default: next_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      payload    <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (bit_en) begin
        if (state == HUNT && match) begin
          bit_cnt <= '0;
          par_acc <= 1'b0;
        end else if (state == DATA) begin
          payload <= {payload[DATA_W-2:0], d};
          par_acc <= par_acc ^ d;
          bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
      end
      if (valid && ready) valid <= 1'b0;
      // A completing frame may reuse the slot freed by a same-edge acceptance.
      if (complete) begin
        if (!valid || ready) begin
          data       <= frame_word;
          parity_err <= frame_perr;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: table-driven first frame, directed
// corner sequences, then random traffic against a bit-queue reference model.
module tb_serial_frame_deserializer;

  localparam int         DATA_W    = 8;
  localparam int         SYNC_W    = 3;
  localparam logic [2:0] SYNC      = 3'b101;
  localparam bit         PARITY_EN = 1'b1;

  logic              clk = 1'b0;
  logic              rst;
  logic              d;
  logic              bit_en;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              overrun;

  int checks = 0;
  int passes = 0;

  serial_frame_deserializer #(
    .DATA_W    (DATA_W),
    .SYNC_W    (SYNC_W),
    .SYNC      (SYNC),
    .PARITY_EN (PARITY_EN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .bit_en     (bit_en),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: raw bit history while hunting, collected frame bits after sync.
  bit              m_hunting = 1'b1;
  bit              hq[$];
  bit              fq[$];
  logic [DATA_W-1:0] m_data  = '0;
  bit              m_valid = 1'b0;
  bit              m_perr  = 1'b0;
  bit              m_ovr   = 1'b0;

  task automatic model_edge(input bit r, input bit en, input bit dd, input bit rdy);
    bit              done;
    bit              accept;
    int              pat;
    int              ones;
    logic [DATA_W-1:0] w;
    bit              pe;
    if (!r) begin
      m_hunting = 1'b1;
      hq.delete();
      fq.delete();
      m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      return;
    end
    done   = 1'b0;
    w      = '0;
    pe     = 1'b0;
    accept = m_valid && rdy;
    m_ovr  = 1'b0;
    if (en) begin
      if (m_hunting) begin
        hq.push_back(dd);
        if (hq.size() > SYNC_W) void'(hq.pop_front());
        if (hq.size() == SYNC_W) begin
          pat = 0;
          for (int k = 0; k < SYNC_W; k++) pat = pat * 2 + int'(hq[k]);
          if (pat == int'(SYNC)) begin
            m_hunting = 1'b0;
            hq.delete();
            fq.delete();
          end
        end
      end else begin
        fq.push_back(dd);
        if (fq.size() == DATA_W + int'(PARITY_EN)) begin
          ones = 0;
          for (int k = 0; k < DATA_W; k++) begin
            w    = DATA_W'(w * 2 + fq[k]);
            ones = ones + int'(fq[k]);
          end
          if (PARITY_EN) pe = ((ones % 2) != int'(fq[DATA_W]));
          done      = 1'b1;
          m_hunting = 1'b1;
          hq.delete();
          fq.delete();
        end
      end
    end
    if (accept) m_valid = 1'b0;
    if (done) begin
      if (!m_valid) begin
        m_data = w; m_perr = pe; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic apply_stimulus(input bit r, input bit en, input bit dd, input bit rdy);
    rst = r; bit_en = en; d = dd; ready = rdy;
    model_edge(r, en, dd, rdy);
    @(posedge clk);
    #1;
    check_output("model_data",  32'(data),       32'(m_data));
    check_output("model_valid", 32'(valid),      32'(m_valid));
    check_output("model_perr",  32'(parity_err), 32'(m_perr));
    check_output("model_ovr",   32'(overrun),    32'(m_ovr));
  endtask

  task automatic send_bit(input bit b, input bit rdy, input bit toggle);
    if (toggle) apply_stimulus(1'b1, 1'b0, ~b, rdy);
    apply_stimulus(1'b1, 1'b1, b, rdy);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input bit par,
                            input bit rdy, input bit toggle);
    logic [SYNC_W-1:0] s;
    s = SYNC;
    for (int i = SYNC_W - 1; i >= 0; i--) send_bit(s[i], rdy, toggle);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i], rdy, toggle);
    send_bit(par, rdy, toggle);
  endtask

  typedef struct {
    bit                rst_n;
    bit                en;
    bit                d;
    bit                rdy;
    logic [DATA_W-1:0] exp_data;
    bit                exp_valid;
    bit                exp_perr;
    bit                exp_ovr;
  } vec_t;

  vec_t        vecs[13];
  logic [11:0] s1_bits;
  logic [5:0]  noise;

  initial begin
    s1_bits = 12'b101_10100011_0;
    for (int i = 0; i < 12; i++)
      vecs[i] = '{1'b1, 1'b1, s1_bits[11-i], 1'b1,
                  (i == 11) ? 8'hA3 : 8'h00, (i == 11), 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};

    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    check_output("reset_data",  32'(data),       32'h0);
    check_output("reset_valid", 32'(valid),      32'h0);
    check_output("reset_perr",  32'(parity_err), 32'h0);
    check_output("reset_ovr",   32'(overrun),    32'h0);

    // Scenario 1: clean frame A3 with correct parity, one-cycle valid.
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].en, vecs[i].d, vecs[i].rdy);
      check_output($sformatf("vec%0d_data", i),  32'(data),       32'(vecs[i].exp_data));
      check_output($sformatf("vec%0d_valid", i), 32'(valid),      32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_perr", i),  32'(parity_err), 32'(vecs[i].exp_perr));
      check_output($sformatf("vec%0d_ovr", i),   32'(overrun),    32'(vecs[i].exp_ovr));
    end

    // Scenario 2: bad parity bit.
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    check_output("s2_data",  32'(data),       32'hA3);
    check_output("s2_valid", 32'(valid),      32'h1);
    check_output("s2_perr",  32'(parity_err), 32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Scenario 3: consumer stalled, second frame overruns.
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    check_output("s3_first_valid", 32'(valid), 32'h1);
    send_frame(8'h5C, 1'b0, 1'b0, 1'b0);
    check_output("s3_ovr_pulse",  32'(overrun), 32'h1);
    check_output("s3_data_kept",  32'(data),    32'hA3);
    check_output("s3_valid_kept", 32'(valid),   32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("s3_ovr_single", 32'(overrun), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    check_output("s3_valid_drop", 32'(valid), 32'h0);

    // Scenario 4: overlapping sync inside noise, payload FF.
    noise = 6'b001101;
    for (int i = 5; i >= 0; i--) begin
      send_bit(noise[i], 1'b1, 1'b0);
      if (i == 1) check_output("s4_no_early_sync", 32'(dut.state), 32'(0));
    end
    check_output("s4_sync_at_6th", 32'(dut.state), 32'(1));
    for (int i = 0; i < DATA_W; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    check_output("s4_data",  32'(data),       32'hFF);
    check_output("s4_valid", 32'(valid),      32'h1);
    check_output("s4_perr",  32'(parity_err), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Scenario 5: bit_en toggling, garbage on disabled cycles.
    send_frame(8'hA3, 1'b0, 1'b1, 1'b1);
    check_output("s5_data",  32'(data),       32'hA3);
    check_output("s5_valid", 32'(valid),      32'h1);
    check_output("s5_perr",  32'(parity_err), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Scenario 6: reset mid-frame, then a fresh frame 3C.
    send_bit(1'b1, 1'b1, 1'b0); send_bit(1'b0, 1'b1, 1'b0); send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2), 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    check_output("s6_rst_valid", 32'(valid),      32'h0);
    check_output("s6_rst_data",  32'(data),       32'h0);
    check_output("s6_rst_perr",  32'(parity_err), 32'h0);
    check_output("s6_rst_ovr",   32'(overrun),    32'h0);
    check_output("s6_rst_state", 32'(dut.state),  32'(0));
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_output("s6_data",  32'(data),       32'h3C);
    check_output("s6_valid", 32'(valid),      32'h1);
    check_output("s6_perr",  32'(parity_err), 32'h0);

    // Random traffic: frequent syncs, stalls and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      apply_stimulus(($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 3) != 0),
                     1'($urandom),
                     ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
